// File: rtl/jk_seq_pkg.sv
// Shared types for the JK command sequencer: op encoding ({j,k}), FSM states,
// and the expected post-update Q for each op.
package jk_seq_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_CLEAR  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_CHECK = 2'b10
  } seq_state_e;

  function automatic logic expected_q(input jk_op_e op, input logic q_now);
    case (op)
      JK_CLEAR:  return 1'b0;
      JK_SET:    return 1'b1;
      JK_TOGGLE: return ~q_now;
      default:   return q_now;
    endcase
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Small synchronous command FIFO with first-word fall-through read.
// Push while full and pop while empty are ignored.
module jk_cmd_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [W-1:0]                 wdata,
  input  logic                         pop,
  output logic [W-1:0]                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign rdata  = r_mem[r_rptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Buffers JK commands and drives one-cycle J/K pulses to a flip-flop bank.
// Define JK_SEQ_CHECK_EN to add the Q readback CHECK state; otherwise done_ok is always 1.
module jk_cmd_sequencer
  import jk_seq_pkg::*;
#(
  parameter int N_FF       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [$clog2(N_FF)-1:0] cmd_idx,
  output logic [N_FF-1:0]         j,
  output logic [N_FF-1:0]         k,
  input  logic [N_FF-1:0]         q,
  output logic                    busy,
  output logic                    done,
  output logic                    done_ok
);
  localparam int IDXW = $clog2(N_FF);
  localparam int CW   = $clog2(FIFO_DEPTH+1);

  seq_state_e      r_state, w_state_nxt;
  logic [N_FF-1:0] r_j, r_k, w_j_nxt, w_k_nxt, w_load_j, w_load_k;
  logic            r_done, r_done_ok, w_done_nxt, w_done_ok_nxt;
  logic            w_pop, w_full, w_empty, w_head_ok;
  logic [IDXW+1:0] w_head;
  jk_op_e          w_head_op;
  logic [IDXW-1:0] w_head_idx;
  logic [CW-1:0]   w_unused_count;

  jk_cmd_fifo #(.W(IDXW+2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid),
    .wdata ({cmd_op, cmd_idx}),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_unused_count)
  );

  assign w_head_op  = jk_op_e'(w_head[IDXW+1 -: 2]);
  assign w_head_idx = w_head[IDXW-1:0];
  assign w_head_ok  = ({1'b0, w_head_idx} < (IDXW+1)'(N_FF));

  // Out-of-range targets still run the sequence, just with no J/K bit set.
  always_comb begin
    w_load_j = '0;
    w_load_k = '0;
    if (w_head_ok) begin
      w_load_j[w_head_idx] = w_head_op[1];
      w_load_k[w_head_idx] = w_head_op[0];
    end
  end

`ifdef JK_SEQ_CHECK_EN
  jk_op_e          r_op;
  logic [IDXW-1:0] r_idx;
  logic            r_idx_ok, r_exp, w_q_bit;

  assign w_q_bit = r_idx_ok & q[r_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op     <= JK_HOLD;
      r_idx    <= '0;
      r_idx_ok <= 1'b0;
      r_exp    <= 1'b0;
    end else begin
      if (w_pop) begin
        r_op     <= w_head_op;
        r_idx    <= w_head_idx;
        r_idx_ok <= w_head_ok;
      end
      if (r_state == ST_DRIVE) r_exp <= expected_q(r_op, w_q_bit);
    end
  end
`else
  logic w_unused_q;
  assign w_unused_q = ^q;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_pop         = 1'b0;
    w_j_nxt       = '0;
    w_k_nxt       = '0;
    w_done_nxt    = 1'b0;
    w_done_ok_nxt = 1'b0;
    case (r_state)
      ST_IDLE: if (!w_empty) begin
        w_pop       = 1'b1;
        w_state_nxt = ST_DRIVE;
        w_j_nxt     = w_load_j;
        w_k_nxt     = w_load_k;
      end
`ifdef JK_SEQ_CHECK_EN
      ST_DRIVE: w_state_nxt = ST_CHECK;
      ST_CHECK: begin
        w_done_nxt    = 1'b1;
        w_done_ok_nxt = r_idx_ok && (w_q_bit == r_exp);
        w_state_nxt   = ST_IDLE;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_DRIVE;
          w_j_nxt     = w_load_j;
          w_k_nxt     = w_load_k;
        end
      end
`else
      ST_DRIVE: begin
        w_done_nxt    = 1'b1;
        w_done_ok_nxt = 1'b1;
        w_state_nxt   = ST_IDLE;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_DRIVE;
          w_j_nxt     = w_load_j;
          w_k_nxt     = w_load_k;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_j       <= '0;
      r_k       <= '0;
      r_done    <= 1'b0;
      r_done_ok <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_j       <= w_j_nxt;
      r_k       <= w_k_nxt;
      r_done    <= w_done_nxt;
      r_done_ok <= w_done_ok_nxt;
    end
  end

  assign j         = r_j;
  assign k         = r_k;
  assign done      = r_done;
  assign done_ok   = r_done_ok;
  assign cmd_ready = !w_full;
  assign busy      = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer with a behavioural JK flip-flop bank;
// expectations follow whichever build (JK_SEQ_CHECK_EN or not) is compiled.
`timescale 1ns/1ps
module tb_jk_cmd_sequencer;
  import jk_seq_pkg::*;

`ifdef JK_SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam int LAT = CHK ? 3 : 2;  // push edge to done edge
  localparam int PER = CHK ? 2 : 1;  // cycles per back-to-back command

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op, cmd_idx;
  logic [3:0] j, k, q, ff_q, stuck0;
  logic       busy, done, done_ok;
  int         tests = 0, fails = 0;

  logic [3:0] lj[16], lk[16], lq[16];
  logic       ld[16], lok[16], lbusy[16];

  jk_cmd_sequencer #(.N_FF(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_idx(cmd_idx), .j(j), .k(k), .q(q),
    .busy(busy), .done(done), .done_ok(done_ok)
  );

  always #5 clk = ~clk;

  // Flip-flop bank: Q+ = J&~Q | ~K&Q
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ff_q <= '0;
    else       ff_q <= (j & ~ff_q) | (~k & ff_q);
  end
  assign q = ff_q & ~stuck0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [1:0] idx);
    cmd_valid = 1'b1; cmd_op = op; cmd_idx = idx;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int c = 1; c <= n; c++) begin
      tick();
      lj[c] = j; lk[c] = k; lq[c] = q; ld[c] = done; lok[c] = done_ok; lbusy[c] = busy;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_idx = 2'b00; stuck0 = '0;
    tick(); tick();
    tests++; if (j !== 4'b0 || k !== 4'b0) begin fails++; $display("FAIL reset_jk act=%b/%b exp=0000/0000", j, k); end
    tests++; if (done !== 1'b0 || done_ok !== 1'b0) begin fails++; $display("FAIL reset_done act=%b/%b exp=0/0", done, done_ok); end
    tests++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_busy_ready act=%b/%b exp=0/1", busy, cmd_ready); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_set();
    push(JK_SET, 2'd2);
    run(6);
    tests++; if (lj[1] !== 4'b0100 || lk[1] !== 4'b0) begin fails++; $display("FAIL set_jk act=%b/%b exp=0100/0000", lj[1], lk[1]); end
    tests++; if (lj[2] !== 4'b0) begin fails++; $display("FAIL set_j_one_cycle act=%b exp=0000", lj[2]); end
    tests++; if (lbusy[1] !== 1'b1) begin fails++; $display("FAIL set_busy act=%b exp=1", lbusy[1]); end
    tests++; if (ld[LAT-1] !== 1'b0 || ld[LAT] !== 1'b1 || ld[LAT+1] !== 1'b0)
      begin fails++; $display("FAIL set_done_timing act=%b%b%b exp=010", ld[LAT-1], ld[LAT], ld[LAT+1]); end
    tests++; if (lok[LAT] !== 1'b1) begin fails++; $display("FAIL set_done_ok act=%b exp=1", lok[LAT]); end
    tests++; if (lq[LAT][2] !== 1'b1) begin fails++; $display("FAIL set_q2 act=%b exp=1", lq[LAT][2]); end
    tests++; if (lbusy[LAT+1] !== 1'b0) begin fails++; $display("FAIL set_idle act=%b exp=0", lbusy[LAT+1]); end
  endtask

  task automatic test_back_to_back();
    logic q0;
    int   nd;
    q0 = q[0];
    push(JK_TOGGLE, 2'd0);
    push(JK_TOGGLE, 2'd0);
    run(10);
    nd = 0;
    for (int c = 1; c <= 10; c++) if (ld[c] === 1'b1) nd++;
    tests++; if (nd !== 2) begin fails++; $display("FAIL b2b_done_count act=%0d exp=2", nd); end
    tests++; if (ld[LAT-1] !== 1'b1 || ld[LAT+PER-1] !== 1'b1)
      begin fails++; $display("FAIL b2b_done_pos act=%b,%b exp=1,1", ld[LAT-1], ld[LAT+PER-1]); end
    tests++; if (lok[LAT-1] !== 1'b1 || lok[LAT+PER-1] !== 1'b1)
      begin fails++; $display("FAIL b2b_done_ok act=%b,%b exp=1,1", lok[LAT-1], lok[LAT+PER-1]); end
    tests++; if (lq[10][0] !== q0) begin fails++; $display("FAIL b2b_q0 act=%b exp=%b", lq[10][0], q0); end
  endtask

  task automatic test_fill();
    int acc, nd;
    logic saw_full;
    acc = 0; nd = 0; saw_full = 1'b0;
    cmd_valid = 1'b1; cmd_op = JK_HOLD; cmd_idx = 2'd0;
    for (int e = 0; e < 8; e++) begin
      if (cmd_ready) acc++; else saw_full = 1'b1;
      tick();
      if (done === 1'b1) nd++;
    end
    cmd_valid = 1'b0;
    run(15);
    for (int c = 1; c <= 15; c++) if (ld[c] === 1'b1) nd++;
    tests++; if (acc !== (CHK ? 7 : 8)) begin fails++; $display("FAIL fill_accepted act=%0d exp=%0d", acc, CHK ? 7 : 8); end
    tests++; if (saw_full !== CHK) begin fails++; $display("FAIL fill_ready_low act=%b exp=%b", saw_full, CHK); end
    tests++; if (nd !== acc) begin fails++; $display("FAIL fill_done_count act=%0d exp=%0d", nd, acc); end
    tests++; if (lbusy[15] !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL fill_drain act=%b/%b exp=0/1", lbusy[15], cmd_ready); end
  endtask

  task automatic test_stuck();
    stuck0 = 4'b0010;
    push(JK_SET, 2'd1);
    run(6);
    tests++; if (ld[LAT] !== 1'b1) begin fails++; $display("FAIL stuck_done act=%b exp=1", ld[LAT]); end
    tests++; if (lok[LAT] !== !CHK) begin fails++; $display("FAIL stuck_done_ok act=%b exp=%b", lok[LAT], !CHK); end
    tests++; if (lq[6][1] !== 1'b0) begin fails++; $display("FAIL stuck_q1 act=%b exp=0", lq[6][1]); end
    stuck0 = '0;
  endtask

  task automatic test_reset_mid();
    int nd;
    nd = 0;
    push(JK_SET, 2'd3);
    push(JK_HOLD, 2'd0);
    tests++; if (j !== 4'b1000) begin fails++; $display("FAIL rmid_drive_j act=%b exp=1000", j); end
    #2 reset = 1'b1;
    #1;
    tests++; if (j !== 4'b0 || k !== 4'b0) begin fails++; $display("FAIL rmid_jk_async act=%b/%b exp=0000/0000", j, k); end
    tests++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL rmid_busy_ready act=%b/%b exp=0/1", busy, cmd_ready); end
    tick();
    @(negedge clk); reset = 1'b0;
    run(6);
    for (int c = 1; c <= 6; c++) if (ld[c] === 1'b1) nd++;
    tests++; if (nd !== 0) begin fails++; $display("FAIL rmid_no_done act=%0d exp=0", nd); end
    tests++; if (lbusy[6] !== 1'b0) begin fails++; $display("FAIL rmid_fifo_empty act=%b exp=0", lbusy[6]); end
  endtask

  task automatic test_clear();
    push(JK_SET, 2'd3);
    run(6);
    push(JK_CLEAR, 2'd3);
    run(6);
    tests++; if (lk[1] !== 4'b1000 || lj[1] !== 4'b0) begin fails++; $display("FAIL clr_jk act=%b/%b exp=0000/1000", lj[1], lk[1]); end
    tests++; if (ld[LAT-1] !== 1'b0 || ld[LAT] !== 1'b1) begin fails++; $display("FAIL clr_done_timing act=%b%b exp=01", ld[LAT-1], ld[LAT]); end
    tests++; if (lok[LAT] !== 1'b1) begin fails++; $display("FAIL clr_done_ok act=%b exp=1", lok[LAT]); end
    tests++; if (lq[LAT][3] !== 1'b0) begin fails++; $display("FAIL clr_q3 act=%b exp=0", lq[LAT][3]); end
  endtask

  initial begin
    test_reset();
    test_set();
    test_back_to_back();
    test_fill();
    test_stuck();
    test_reset_mid();
    test_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
